// File: rtl/terminal_text_controller.sv
// terminal_text_controller
//   Owns the ROWS x COLS character buffer feeding the terminal renderer.
//   Printable bytes are written at the cursor and advance it. Newline, CR,
//   backspace and form feed (clear) are handled as control codes. Scroll and
//   clear run one row per cycle while char_ready is held low.
// Ports:
//   clock, resetn        system clock, async active-low reset
//   char_in/char_valid   input byte and its valid strobe
//   char_ready           byte accepted this cycle (state == IDLE)
//   character_array      buffer, cell (r,c) at [(r*COLS+c)*8 +: 8]
//   cursor_row/col       current cursor position
//   busy                 high during SCROLL or CLEAR
module terminal_text_controller #(
  parameter int          ROWS  = 7,
  parameter int          COLS  = 32,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic [7:0]                     char_in,
  input  logic                           char_valid,
  output logic                           char_ready,
  output logic [ROWS*COLS*8-1:0]         character_array,
  output logic [$clog2(ROWS)-1:0]        cursor_row,
  output logic [$clog2(COLS)-1:0]        cursor_col,
  output logic                           busy
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, SCROLL, CLEAR} state_t;

  state_t                            state;
  logic [RW-1:0]                     k;
  logic [RW-1:0]                     row;
  logic [CW-1:0]                     col;
  // Packed so the flattened layout matches (r*COLS+c)*8 directly.
  logic [ROWS-1:0][COLS-1:0][7:0]    cells;

  assign character_array = cells;
  assign cursor_row      = row;
  assign cursor_col      = col;
  assign char_ready      = (state == IDLE);
  assign busy            = (state != IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      k     <= '0;
      row   <= '0;
      col   <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          cells[r][c] <= BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (char_valid) begin
            if (char_in >= 8'h20 && char_in <= 8'h7E) begin
              cells[row][col] <= char_in;
              if (col < LAST_COL) begin
                col <= col + 1'b1;
              end else begin
                col <= '0;
                // Wrapping off the bottom row keeps the cursor there and
                // lets the scroll open a fresh line underneath it.
                if (row < LAST_ROW) row <= row + 1'b1;
                else                state <= SCROLL;
              end
            end else begin
              case (char_in)
                8'h0A: begin
                  col <= '0;
                  if (row < LAST_ROW) row <= row + 1'b1;
                  else                state <= SCROLL;
                end
                8'h0D: col <= '0;
                8'h08: begin
                  if (col != '0) begin
                    col <= col - 1'b1;
                    cells[row][col - 1'b1] <= BLANK;
                  end else if (row != '0) begin
                    row <= row - 1'b1;
                    col <= LAST_COL;
                    cells[row - 1'b1][LAST_COL] <= BLANK;
                  end
                end
                8'h0C:   state <= CLEAR;
                default: ;
              endcase
            end
          end
        end
        SCROLL: begin
          if (k < LAST_ROW) begin
            cells[k] <= cells[k + 1'b1];
            k        <= k + 1'b1;
          end else begin
            cells[LAST_ROW] <= {COLS{BLANK}};
            k               <= '0;
            state           <= IDLE;
          end
        end
        CLEAR: begin
          cells[k] <= {COLS{BLANK}};
          if (k == LAST_ROW) begin
            k     <= '0;
            row   <= '0;
            col   <= '0;
            state <= IDLE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_terminal_text_controller.sv
module tb_terminal_text_controller;
  localparam int ROWS = 7;
  localparam int COLS = 32;

  logic                   clock = 0;
  logic                   resetn;
  logic [7:0]             char_in;
  logic                   char_valid;
  logic                   char_ready;
  logic [ROWS*COLS*8-1:0] character_array;
  logic [2:0]             cursor_row;
  logic [4:0]             cursor_col;
  logic                   busy;

  terminal_text_controller dut (
    .clock(clock), .resetn(resetn), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .character_array(character_array),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference screen: plain 2-D array plus cursor.
  logic [7:0] m [ROWS][COLS];
  int mr, mc;

  function automatic void model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m[r][c] = 8'h20;
    mr = 0; mc = 0;
  endfunction

  // Applies one accepted byte; returns the number of busy cycles it causes.
  function automatic int model_apply(logic [7:0] b);
    int busy_cycles = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      m[mr][mc] = b;
      mc++;
      if (mc == COLS) begin
        mc = 0;
        if (mr == ROWS - 1) busy_cycles = ROWS; else mr++;
      end
    end else if (b == 8'h0A) begin
      mc = 0;
      if (mr == ROWS - 1) busy_cycles = ROWS; else mr++;
    end else if (b == 8'h0D) begin
      mc = 0;
    end else if (b == 8'h08) begin
      if (mc > 0) begin mc--; m[mr][mc] = 8'h20; end
      else if (mr > 0) begin mr--; mc = COLS - 1; m[mr][mc] = 8'h20; end
    end else if (b == 8'h0C) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) m[r][c] = 8'h20;
      mr = 0; mc = 0;
      busy_cycles = ROWS;
    end
    if (busy_cycles != 0 && b != 8'h0C) begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) m[r][c] = m[r+1][c];
      for (int c = 0; c < COLS; c++) m[ROWS-1][c] = 8'h20;
    end
    return busy_cycles;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_screen(input string name);
    int bad_r = -1, bad_c = -1;
    logic [7:0] got;
    n_checks++;
    for (int r = ROWS - 1; r >= 0; r--)
      for (int c = COLS - 1; c >= 0; c--) begin
        got = character_array[(r*COLS+c)*8 +: 8];
        if (got !== m[r][c]) begin bad_r = r; bad_c = c; end
      end
    if (bad_r >= 0) begin
      n_fail++;
      $display("FAIL %s: cell (%0d,%0d) got 0x%0h, expected 0x%0h", name, bad_r, bad_c,
               character_array[(bad_r*COLS+bad_c)*8 +: 8], m[bad_r][bad_c]);
    end
  endtask

  task automatic chk_cursor(input string name);
    chk({name, " row"}, int'(cursor_row), mr);
    chk({name, " col"}, int'(cursor_col), mc);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 0; char_valid = 0; char_in = 8'h00;
    model_reset();
    @(negedge clock);
    resetn = 1;
  endtask

  // One clock with the given inputs; valid drops just after the edge.
  task automatic cycle(input logic v, input logic [7:0] b);
    @(negedge clock);
    char_valid = v; char_in = b;
    @(posedge clock);
    #1 char_valid = 0;
  endtask

  task automatic send(input logic [7:0] b, output int bc);
    cycle(1'b1, b);
    bc = model_apply(b);
  endtask

  // Counts cycles with char_ready low, bounded.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    repeat (50) begin
      @(negedge clock);
      if (char_ready) return;
      cnt++;
    end
  endtask

  typedef struct {
    logic [7:0] b;
    int         row;
    int         col;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int bc, cnt, pick;
    logic [7:0] b;

    tbl[0] = '{8'h41, 0, 1};
    tbl[1] = '{8'h41, 0, 2};
    tbl[2] = '{8'h41, 0, 3};
    tbl[3] = '{8'h0D, 0, 0};
    tbl[4] = '{8'h08, 0, 0};
    tbl[5] = '{8'h7F, 0, 0};
    tbl[6] = '{8'h80, 0, 0};
    tbl[7] = '{8'h0A, 1, 0};
    tbl[8] = '{8'h08, 0, 31};

    resetn = 0; char_valid = 0; char_in = 0;
    model_reset();
    #12;
    chk_screen("reset screen");
    chk("reset ready", int'(char_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset row", int'(cursor_row), 0);
    chk("reset col", int'(cursor_col), 0);
    do_reset();

    // Table vectors, back to back.
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].b, bc);
      chk($sformatf("vec%0d row", i), int'(cursor_row), tbl[i].row);
      chk($sformatf("vec%0d col", i), int'(cursor_col), tbl[i].col);
      chk($sformatf("vec%0d ready", i), int'(char_ready), 1);
      chk_screen($sformatf("vec%0d screen", i));
    end
    chk("vec cell(0,2)", int'(character_array[2*8 +: 8]), 8'h41);
    chk("vec cell(0,31)", int'(character_array[31*8 +: 8]), 8'h20);

    // Wrap from end of row 0.
    do_reset();
    for (int i = 0; i < 31; i++) send(8'h61, bc);
    chk("col31 pre", int'(cursor_col), 31);
    send(8'h42, bc);
    chk("wrap cell(0,31)", int'(character_array[31*8 +: 8]), 8'h42);
    chk("wrap row", int'(cursor_row), 1);
    chk("wrap col", int'(cursor_col), 0);
    chk("wrap busy", int'(busy), 0);

    // Newline at the bottom row scrolls.
    do_reset();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) send(8'h30 + 8'(r), bc);
    for (int c = 0; c < 5; c++) send(8'h36, bc);
    chk("pre-scroll row", int'(cursor_row), 6);
    chk("pre-scroll col", int'(cursor_col), 5);
    send(8'h0A, bc);
    wait_idle(cnt);
    chk("scroll busy cycles", cnt, 7);
    chk("scroll model cycles", bc, 7);
    chk("scroll row1 now row0", int'(character_array[0 +: 8]), 8'h31);
    chk_screen("scroll screen");
    chk_cursor("scroll cursor");

    // Backspace across a row boundary.
    do_reset();
    for (int i = 0; i < 2*COLS; i++) send(8'h63, bc);
    chk("bs pre row", int'(cursor_row), 2);
    send(8'h08, bc);
    chk("bs row", int'(cursor_row), 1);
    chk("bs col", int'(cursor_col), 31);
    chk("bs cell(1,31)", int'(character_array[(COLS+31)*8 +: 8]), 8'h20);
    chk_screen("bs screen");

    // Form feed with a byte held valid throughout the clear.
    send(8'h0C, bc);
    char_valid = 1; char_in = 8'h51;
    wait_idle(cnt);
    chk("clear busy cycles", cnt, 7);
    chk_screen("clear screen");
    chk("clear row", int'(cursor_row), 0);
    chk("clear col", int'(cursor_col), 0);
    @(posedge clock);
    #1 char_valid = 0;
    bc = model_apply(8'h51);
    chk("held byte col", int'(cursor_col), 1);
    chk_screen("held byte screen");

    // Reset during the third cycle of a scroll.
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A, bc);
    send(8'h5A, bc);
    send(8'h0A, bc);
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    @(negedge clock);
    chk("mid-scroll busy", int'(busy), 1);
    resetn = 0;
    model_reset();
    #1;
    chk_screen("abort screen");
    chk("abort row", int'(cursor_row), 0);
    chk("abort col", int'(cursor_col), 0);
    @(negedge clock);
    resetn = 1;
    @(negedge clock);
    chk("abort ready", int'(char_ready), 1);
    chk_screen("abort screen after release");

    // Random stream against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      pick = $urandom_range(0, 99);
      if (pick < 70)      b = 8'($urandom_range(8'h20, 8'h7E));
      else if (pick < 78) b = 8'h0A;
      else if (pick < 83) b = 8'h0D;
      else if (pick < 92) b = 8'h08;
      else if (pick < 94) b = 8'h0C;
      else                b = 8'($urandom_range(0, 255));
      send(b, bc);
      if (bc != 0) begin
        wait_idle(cnt);
        chk($sformatf("rnd%0d busy cycles", i), cnt, bc);
      end else begin
        chk($sformatf("rnd%0d ready", i), int'(char_ready), 1);
      end
      chk_cursor($sformatf("rnd%0d", i));
      chk_screen($sformatf("rnd%0d screen", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
